// File: rtl/stream_demux_1to4_if.sv
// Valid/ready bundle for the 1-to-4 stream demux: one upstream port, four
// downstream channels and their transfer counters.
interface stream_demux_1to4_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [N-1:0]     in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [N-1:0]     out_data0;
    logic [N-1:0]     out_data1;
    logic [N-1:0]     out_data2;
    logic [N-1:0]     out_data3;
    logic [CNT_W-1:0] out_cnt0;
    logic [CNT_W-1:0] out_cnt1;
    logic [CNT_W-1:0] out_cnt2;
    logic [CNT_W-1:0] out_cnt3;

    // Source side drives the upstream word and the consumer readies.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               out_cnt0, out_cnt1, out_cnt2, out_cnt3
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               out_cnt0, out_cnt1, out_cnt2, out_cnt3
    );
endinterface

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer: each accepted word lands in the
// one-entry slot of the channel chosen by in_sel; completed transfers are counted.
module stream_demux_1to4 #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_demux_1to4_if.slave   bus
);
    localparam int unsigned NCH = 4;

    logic [NCH-1:0]   slot_valid;
    logic [N-1:0]     slot_data [NCH];
    logic [CNT_W-1:0] cnt       [NCH];
    logic             in_ready_c;
    logic             accept_c;
    logic [NCH-1:0]   load_c;
    logic [NCH-1:0]   drain_c;

    // A slot can take a new word when empty or when it is draining this cycle.
    always_comb begin
        in_ready_c = ~slot_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
        accept_c   = bus.in_valid & in_ready_c;
        load_c     = '0;
        drain_c    = '0;
        for (int k = 0; k < NCH; k++) begin
            load_c[k]  = accept_c & (bus.in_sel == 2'(k));
            drain_c[k] = slot_valid[k] & bus.out_ready[k];
        end
    end

    // Reload wins over drain so a channel sustains one word per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int k = 0; k < NCH; k++) begin
                slot_data[k] <= '0;
                cnt[k]       <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                slot_valid[k] <= load_c[k] | (slot_valid[k] & ~drain_c[k]);
                if (load_c[k]) begin
                    slot_data[k] <= bus.in_data;
                end
                if (drain_c[k]) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = slot_valid;
    assign bus.out_data0 = slot_data[0];
    assign bus.out_data1 = slot_data[1];
    assign bus.out_data2 = slot_data[2];
    assign bus.out_data3 = slot_data[3];
    assign bus.out_cnt0  = cnt[0];
    assign bus.out_cnt1  = cnt[1];
    assign bus.out_cnt2  = cnt[2];
    assign bus.out_cnt3  = cnt[3];
endmodule

// File: tb/tb_stream_demux_1to4.sv
// Self-checking bench for stream_demux_1to4: directed scenarios plus a
// per-channel scoreboard that tracks every accepted word until it drains.
module tb_stream_demux_1to4;
    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_demux_1to4_if #(.N(N), .CNT_W(CNT_W)) bus ();

    stream_demux_1to4 #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [N-1:0]     q [4][$];
    logic [CNT_W-1:0] exp_cnt [4];
    bit               mon_en = 1'b0;

    function automatic logic [N-1:0] get_data(input int k);
        case (k)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] get_cnt(input int k);
        case (k)
            0:       return bus.out_cnt0;
            1:       return bus.out_cnt1;
            2:       return bus.out_cnt2;
            default: return bus.out_cnt3;
        endcase
    endfunction

    // Scoreboard monitor: samples just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && !rst) begin
                checks++;
                if (bus.in_ready !== 1'((q[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel])) begin
                    failures++;
                    $display("FAIL sb_in_ready sel=%0d: got %b want %b", bus.in_sel, bus.in_ready,
                             1'((q[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel]));
                end
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (bus.out_valid[k] !== 1'(q[k].size() != 0)) begin
                        failures++;
                        $display("FAIL sb_valid ch%0d: got %b want %b", k, bus.out_valid[k],
                                 1'(q[k].size() != 0));
                    end else if (bus.out_valid[k]) begin
                        checks++;
                        if (get_data(k) !== q[k][0]) begin
                            failures++;
                            $display("FAIL sb_data ch%0d: got %h want %h", k, get_data(k), q[k][0]);
                        end
                        if (bus.out_ready[k]) begin
                            void'(q[k].pop_front());
                            exp_cnt[k] = exp_cnt[k] + CNT_W'(1);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) q[bus.in_sel].push_back(bus.in_data);
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            exp_cnt[k] = '0;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic push_word(input logic [1:0] sel, input logic [N-1:0] data);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_counts(input string name);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (get_cnt(k) !== exp_cnt[k]) begin
                failures++;
                $display("FAIL %s cnt%0d: got %0d want %0d", name, k, get_cnt(k), exp_cnt[k]);
            end
        end
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            failures++; $display("FAIL reset_valid: got %b want 0000", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (get_cnt(k) !== '0 || get_data(k) !== '0) begin
                failures++;
                $display("FAIL reset_ch%0d: cnt %0d data %h want 0/0", k, get_cnt(k), get_data(k));
            end
        end
        do_reset();
    endtask

    task automatic test_route_stall();
        do_reset();
        push_word(2'd2, 32'hAAAAAAAA);
        #1;
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_data2 !== 32'hAAAAAAAA) begin
            failures++;
            $display("FAIL route: valid %b data2 %h want 0100 aaaaaaaa", bus.out_valid, bus.out_data2);
        end
        bus.in_sel = 2'd2; #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL stall_ready_sel2: got %b want 0", bus.in_ready);
        end
        bus.in_sel = 2'd1; #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL stall_ready_sel1: got %b want 1", bus.in_ready);
        end
        // Another channel still accepts while channel 2 stalls.
        push_word(2'd1, 32'h00000011);
        repeat (2) @(negedge clk);
        bus.out_ready = 4'b0110;
        @(negedge clk);
        bus.out_ready = 4'b0000;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            failures++; $display("FAIL stall_drain: valid %b want 0000", bus.out_valid);
        end
        check_counts("stall_drain");
    endtask

    task automatic test_drain_load();
        do_reset();
        push_word(2'd3, 32'h80000001);
        bus.out_ready = 4'b1000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        bus.in_data   = 32'h00000001;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        checks++;
        if (bus.out_valid[3] !== 1'b1 || bus.out_data3 !== 32'h1 || bus.out_cnt3 !== 8'd1) begin
            failures++;
            $display("FAIL drain_load: valid3 %b data3 %h cnt3 %0d want 1 00000001 1",
                     bus.out_valid[3], bus.out_data3, bus.out_cnt3);
        end
    endtask

    task automatic test_fill_drain();
        logic [N-1:0] words [4];
        words[0] = 32'h0; words[1] = 32'h1; words[2] = 32'hAAAAAAAA; words[3] = 32'h80000001;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(k);
            bus.in_data  = words[k];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 4'b1111) begin
            failures++; $display("FAIL fill_valid: got %b want 1111", bus.out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (get_data(k) !== words[k]) begin
                failures++; $display("FAIL fill_data%0d: got %h want %h", k, get_data(k), words[k]);
            end
        end
        bus.out_ready = 4'b1111;
        @(negedge clk);
        bus.out_ready = 4'b0000;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            failures++; $display("FAIL fill_drain_valid: got %b want 0000", bus.out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (get_cnt(k) !== 8'd1) begin
                failures++; $display("FAIL fill_drain_cnt%0d: got %0d want 1", k, get_cnt(k));
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        bus.out_ready = 4'b0001;
        // 257 loads give 256 completed transfers with the last word still held.
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'd0;
            bus.in_data  = 32'(i);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        checks++;
        if (bus.out_cnt0 !== 8'd0 || bus.out_valid[0] !== 1'b1 || bus.out_data0 !== 32'd256) begin
            failures++;
            $display("FAIL wrap_ch0: cnt0 %0d valid0 %b data0 %0d want 0 1 256",
                     bus.out_cnt0, bus.out_valid[0], bus.out_data0);
        end
        checks++;
        if (bus.out_cnt1 !== 8'd0 || bus.out_cnt2 !== 8'd0 || bus.out_cnt3 !== 8'd0) begin
            failures++;
            $display("FAIL wrap_others: cnt1 %0d cnt2 %0d cnt3 %0d want 0 0 0",
                     bus.out_cnt1, bus.out_cnt2, bus.out_cnt3);
        end
        check_counts("wrap");
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_word(2'd1, 32'h12345678);
        bus.out_ready = 4'b0010;
        @(negedge clk);
        bus.out_ready = 4'b0000;
        push_word(2'd1, 32'hDEADBEEF);
        push_word(2'd2, 32'hCAFEF00D);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            failures++; $display("FAIL midrst_valid: got %b want 0000", bus.out_valid);
        end
        checks++;
        if (bus.out_cnt0 !== 8'd0 || bus.out_cnt1 !== 8'd0 || bus.out_cnt2 !== 8'd0 || bus.out_cnt3 !== 8'd0) begin
            failures++;
            $display("FAIL midrst_cnt: %0d %0d %0d %0d want all 0",
                     bus.out_cnt0, bus.out_cnt1, bus.out_cnt2, bus.out_cnt3);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
        push_word(2'd1, 32'h55555555);
        #1;
        checks++;
        if (bus.out_valid !== 4'b0010 || bus.out_data1 !== 32'h55555555) begin
            failures++;
            $display("FAIL midrst_after: valid %b data1 %h want 0010 55555555", bus.out_valid, bus.out_data1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        clear_model();
        test_reset();
        test_route_stall();
        test_drain_load();
        test_fill_drain();
        test_counter_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
